adder_error_monitor: RTL
========================

ADDER_ERROR_MONITOR -- requirements
Module: adder_error_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 32: adder operand width; the sum is WIDTH+1 bits.
REQ-002 SHALL have parameter CNT_W, default 32: width of the sample and error counters.
REQ-003 SHALL have parameter ACC_W, default 64: width of the error-distance accumulator.
REQ-004 SHALL have port clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port clear  in  1  synchronous statistics clear.
REQ-007 SHALL have port in_valid  in  1  sample present on op_a/op_b/approx_sum.
REQ-008 SHALL have port in_ready  out  1  block accepts a sample this cycle.
REQ-009 SHALL have ports op_a, op_b  in  WIDTH  operands that were applied to the adder under test.
REQ-010 SHALL have port approx_sum  in  WIDTH+1  result produced by the (approximate) adder under test.
REQ-011 SHALL have port snap_req  in  1  request a stable statistics snapshot.
REQ-012 SHALL have port snap_valid  out  1  snapshot outputs are stable and complete.
REQ-013 SHALL have port snap_ready  in  1  consumer accepts the snapshot.
REQ-014 SHALL have ports sample_cnt, err_cnt  out  CNT_W  accepted-sample count and nonzero-error count.
REQ-015 SHALL have port err_dist_sum  out  ACC_W  sum of error distances.
REQ-016 SHALL have port err_dist_max  out  WIDTH+1  maximum error distance.
REQ-017 SHALL have port busy  out  1  state is not RUN, or a pipeline stage holds a valid sample.

Function
REQ-018 SHALL accept a sample on each rising edge where in_valid && in_ready.
REQ-019 SHALL drive in_ready = (state==RUN) && !clear.
REQ-020 SHALL compute exact = {0,op_a} + {0,op_b} (WIDTH+1 bits, no loss).
REQ-021 SHALL compute err_dist = |exact - approx_sum| as unsigned WIDTH+1, with no wrap.
REQ-022 SHALL have a three-stage pipeline:
- edge N: register exact, approx_sum and valid;
- edge N+1: register err_dist and valid;
- edge N+2: update the statistics.
REQ-023 SHALL, per retired sample, increment sample_cnt; increment err_cnt iff err_dist != 0; add err_dist to err_dist_sum; set err_dist_max = err_dist when err_dist > err_dist_max.
REQ-024 SHALL saturate sample_cnt, err_cnt and err_dist_sum at all-ones; they never wrap.
REQ-025 SHALL have FSM states RUN, DRAIN, REPORT.
REQ-026 SHALL go RUN -> DRAIN when snap_req=1 in RUN; a sample accepted in that same cycle is included in the snapshot.
REQ-027 SHALL go DRAIN -> REPORT on the first cycle in which both pipeline valid bits are 0.
REQ-028 SHALL hold snap_valid=1 in REPORT, with all statistics outputs stable.
REQ-029 SHALL go REPORT -> RUN on snap_valid && snap_ready; statistics are retained, not cleared.
REQ-030 SHALL keep snap_valid=0 in every state other than REPORT.
REQ-031 SHALL ignore snap_req in DRAIN and REPORT.
REQ-032 SHALL honour clear only in RUN, where it zeroes all statistics and both pipeline valid bits on the next edge.
REQ-033 SHALL give clear priority over a sample retiring in the same cycle; that sample is discarded.
REQ-034 SHALL ignore clear in DRAIN and REPORT.
REQ-035 SHALL keep statistics outputs live in RUN; they are guaranteed consistent only while snap_valid=1.

Reset
REQ-036 SHALL, on rst=1 at a clock edge, set state=RUN, clear both pipeline valid bits, and zero all statistics.
REQ-037 SHALL give rst priority over clear, snap_req and in_valid.
REQ-038 SHALL, after a reset that aborts DRAIN or REPORT, return to RUN with snap_valid=0 and discard any in-flight samples.
REQ-039 SHALL drive these output values while rst=1 and on the cycle after: in_ready=1 (when clear=0), snap_valid=0, busy=0, sample_cnt=0, err_cnt=0, err_dist_sum=0, err_dist_max=0.

Verification
REQ-040 SHALL cover reset: hold rst 2 cycles -> all counters 0, snap_valid=0, busy=0, in_ready=1.
REQ-041 SHALL cover an exact carry-out sample: op_a=0xFFFFFFFF, op_b=1, approx_sum=0x100000000, then snap_req -> snap_valid with sample_cnt=1, err_cnt=0, err_dist_sum=0, err_dist_max=0.
REQ-042 SHALL cover error accumulation, three samples then snapshot:
- (5, 3, approx 6): distance 2;
- (0, 0, approx 0x100000000): distance 0x100000000;
- (7, 7, approx 14): distance 0;
- required result: sample_cnt=3, err_cnt=2, err_dist_sum=0x100000002, err_dist_max=0x100000000.
REQ-043 SHALL cover snapshot backpressure: hold snap_ready=0 for 10 cycles in REPORT -> snap_valid stays 1, in_ready=0, outputs unchanged; then snap_ready=1 -> RUN next cycle with statistics retained.
REQ-044 SHALL cover saturation: with CNT_W=4, 20 samples each of distance 1 -> sample_cnt=15, err_cnt=15, err_dist_sum=20.
REQ-045 SHALL cover clear and reset interaction:
- clear in the cycle a sample retires -> all statistics 0;
- rst asserted during DRAIN -> RUN, snap_valid=0, counters 0.

Source files
------------

// File: rtl/adder_error_monitor.sv
// Measures the error of an approximate adder: compares each sample's sum against the exact sum and
// accumulates count, nonzero-error count, total and maximum error distance, with a snapshot handshake.
module adder_error_monitor #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned ACC_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH:0]   approx_sum,
    input  logic             snap_req,
    output logic             snap_valid,
    input  logic             snap_ready,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ACC_W-1:0] err_dist_sum,
    output logic [WIDTH:0]   err_dist_max,
    output logic             busy
);

    // Wide enough that adding one distance to the accumulator can never wrap before saturation.
    localparam int unsigned SumW = ((ACC_W > WIDTH + 1) ? ACC_W : WIDTH + 1) + 1;

    typedef enum logic [1:0] {StRun, StDrain, StReport} state_e;

    state_e           state_q, state_d;
    logic             snap_valid_q, snap_valid_d;
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH:0]   exact_q, exact_d;
    logic [WIDTH:0]   approx_q, approx_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH:0]   dist_q, dist_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [WIDTH:0]   max_q, max_d;
    logic [SumW-1:0]  sum_ext;
    logic             accept;
    logic             do_clear;

    assign in_ready = (rst || state_q == StRun) && !clear;
    assign accept   = in_valid && in_ready && !rst;
    assign do_clear = clear && state_q == StRun;

    always_comb begin
        s1_valid_d = accept;
        exact_d    = exact_q;
        approx_d   = approx_q;
        if (accept) begin
            exact_d  = (WIDTH + 1)'(op_a) + (WIDTH + 1)'(op_b);
            approx_d = approx_sum;
        end

        s2_valid_d = s1_valid_q;
        dist_d     = dist_q;
        if (s1_valid_q) begin
            dist_d = (exact_q >= approx_q) ? exact_q - approx_q : approx_q - exact_q;
        end

        sum_ext      = SumW'(sum_q) + SumW'(dist_q);
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        sum_d        = sum_q;
        max_d        = max_q;
        if (do_clear) begin
            s1_valid_d   = 1'b0;
            s2_valid_d   = 1'b0;
            sample_cnt_d = '0;
            err_cnt_d    = '0;
            sum_d        = '0;
            max_d        = '0;
        end else if (s2_valid_q) begin
            if (!(&sample_cnt_q)) sample_cnt_d = sample_cnt_q + CNT_W'(1);
            if (dist_q != '0 && !(&err_cnt_q)) err_cnt_d = err_cnt_q + CNT_W'(1);
            sum_d = (sum_ext > SumW'({ACC_W{1'b1}})) ? '1 : sum_ext[ACC_W-1:0];
            if (dist_q > max_q) max_d = dist_q;
        end

        state_d = state_q;
        unique case (state_q)
            StRun:    if (snap_req) state_d = StDrain;
            StDrain:  if (!s1_valid_q && !s2_valid_q) state_d = StReport;
            StReport: if (snap_valid_q && snap_ready) state_d = StRun;
            default:  state_d = StRun;
        endcase
        snap_valid_d = (state_d == StReport);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StRun;
            snap_valid_q <= 1'b0;
            s1_valid_q   <= 1'b0;
            exact_q      <= '0;
            approx_q     <= '0;
            s2_valid_q   <= 1'b0;
            dist_q       <= '0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            sum_q        <= '0;
            max_q        <= '0;
        end else begin
            state_q      <= state_d;
            snap_valid_q <= snap_valid_d;
            s1_valid_q   <= s1_valid_d;
            exact_q      <= exact_d;
            approx_q     <= approx_d;
            s2_valid_q   <= s2_valid_d;
            dist_q       <= dist_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            sum_q        <= sum_d;
            max_q        <= max_d;
        end
    end

    // Outputs read as idle/zero while reset is held, whatever the state before it.
    assign snap_valid   = snap_valid_q && !rst;
    assign busy         = !rst && (state_q != StRun || s1_valid_q || s2_valid_q);
    assign sample_cnt   = rst ? '0 : sample_cnt_q;
    assign err_cnt      = rst ? '0 : err_cnt_q;
    assign err_dist_sum = rst ? '0 : sum_q;
    assign err_dist_max = rst ? '0 : max_q;

endmodule
